fetch_pc_unit: RTL and testbench

//  Instruction-fetch stage: owns the program counter, issues word reads to instruction memory,

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/next_pc_calc.sv | 34 +++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 tb/tb_fetch_pc_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and small arithmetic helpers for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  function automatic logic [31:0] adder(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [31:0] expand(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Word offset to byte offset; the top two bits fall off (mod 2^32 arithmetic).
  function automatic logic [31:0] multiply4(input logic [31:0] value);
    return {value[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > PC+4.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_imm,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign pc_plus4   = adder(pc, PC_STEP);
  assign br_target  = adder(pc_plus4, multiply4(expand(br_imm)));
  assign jmp_target = {pc_plus4[31:28], jmp_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jmp) begin
      next_pc = jmp_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, single-outstanding imem request FSM and one-entry instruction buffer.
// Optional FETCH_ALIGN_CHECK_EN traps on misaligned JR targets instead of masking them.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_valid,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_instr_ready,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_imm,
  input  logic        i_jmp,
  input  logic [25:0] i_jmp_imm,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic        o_misalign
);

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] next_pc;
  logic [31:0] jr_target;
  logic        jr_misalign;
  logic        consume;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;

  assign jr_target   = i_jr_target;
  assign jr_misalign = i_jr && (i_jr_target[1:0] != 2'b00);
  assign o_misalign  = misalign;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misalign <= 1'b0;
    end else if (consume && jr_misalign) begin
      misalign <= 1'b1;
    end
  end
`else
  assign jr_target   = i_jr_target & ~32'h0000_0003;
  assign jr_misalign = 1'b0;
  assign o_misalign  = 1'b0;
`endif

  assign consume = (state == S_OUT) && i_instr_ready;

  next_pc_calc u_next_pc_calc (
    .pc        (pc),
    .br_taken  (i_br_taken),
    .br_imm    (i_br_imm),
    .jmp       (i_jmp),
    .jmp_imm   (i_jmp_imm),
    .jr        (i_jr),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .pc_plus4  (o_pc_plus4)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_REQ:   if (i_imem_ready) next_state = S_WAIT;
      S_WAIT:  if (i_imem_rvalid) next_state = S_OUT;
      S_OUT:   if (i_instr_ready) next_state = jr_misalign ? S_TRAP : S_REQ;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_REQ;
    endcase
  end

  // rvalid is only honoured in S_WAIT, so stale responses after a reset are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
    end else if ((state == S_WAIT) && i_imem_rvalid) begin
      instr       <= i_imem_rdata;
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
      if (!jr_misalign) begin
        pc <= next_pc;
      end
    end
  end

  assign o_imem_valid  = (state == S_REQ);
  assign o_imem_addr   = pc;
  assign o_pc          = pc;
  assign o_instr       = instr;
  assign o_instr_valid = instr_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected requests/instructions,
// a negedge monitor pops and compares whenever a handshake is about to complete.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ready;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_imm;
  logic        jr;
  logic [31:0] jr_target;
  logic        misalign;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } instr_exp_t;

  logic [31:0] req_q[$];
  instr_exp_t  instr_q[$];
  int          checks = 0;
  int          errors = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_valid  (imem_valid),
    .o_imem_addr   (imem_addr),
    .i_imem_ready  (imem_ready),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .i_instr_ready (instr_ready),
    .i_br_taken    (br_taken),
    .i_br_imm      (br_imm),
    .i_jmp         (jmp),
    .i_jmp_imm     (jmp_imm),
    .i_jr          (jr),
    .i_jr_target   (jr_target),
    .o_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after posedge, so at negedge both sides of a handshake are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_valid && imem_ready) begin
        if (req_q.size() == 0) begin
          checkOutput("unexpected_request", imem_addr, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] exp_addr;
          exp_addr = req_q.pop_front();
          checkOutput("imem_addr", imem_addr, exp_addr);
        end
      end
      if (instr_valid && instr_ready) begin
        if (instr_q.size() == 0) begin
          checkOutput("unexpected_instr", instr, 32'hFFFF_FFFF);
        end else begin
          instr_exp_t e;
          e = instr_q.pop_front();
          checkOutput("instr", instr, e.data);
          checkOutput("pc", pc, e.pc);
          checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  // One complete fetch: request at exp_addr, data one cycle later, optional decode stall, then consume
  // with the given redirect controls.
  task automatic applyStimulus(input logic [31:0] exp_addr, input logic [31:0] data, input int hold,
                               input bit check_lat, input logic br, input logic [15:0] bimm,
                               input logic j, input logic [25:0] jimm, input logic r, input logic [31:0] rt);
    int n;
    instr_exp_t e;
    e.pc   = exp_addr;
    e.data = data;
    req_q.push_back(exp_addr);
    instr_q.push_back(e);
    imem_ready = 1'b1;
    n = 0;
    while (!imem_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checkOutput("req_timeout", 32'(n), 32'd0);
    end else if (check_lat) begin
      checkOutput("req_latency", 32'(n), 32'd0);
    end
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_instr_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("hold_instr", instr, data);
      checkOutput("hold_pc", pc, exp_addr);
      checkOutput("hold_no_req", {31'b0, imem_valid}, 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    br_taken    = br;
    br_imm      = bimm;
    jmp         = j;
    jmp_imm     = jimm;
    jr          = r;
    jr_target   = rt;
    tick();
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_imm      = 16'h0;
    jmp         = 1'b0;
    jmp_imm     = 26'h0;
    jr          = 1'b0;
    jr_target   = 32'h0;
  endtask

  initial begin
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_imm      = 16'h0;
    jmp         = 1'b0;
    jmp_imm     = 26'h0;
    jr          = 1'b0;
    jr_target   = 32'h0;
    tick();
    tick();
    checkOutput("rst_imem_valid", {31'b0, imem_valid}, 32'd1);
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;

    $display("[TB] sequential fetch 0,4,8,C");
    applyStimulus(32'h0000_0000, 32'hA000_0000, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h0000_0004, 32'hA000_0001, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h0000_0008, 32'hA000_0002, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h0000_000C, 32'hA000_0003, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("[TB] decode stall at 0x10, then branch to 0x100");
    applyStimulus(32'h0000_0010, 32'hB000_0010, 5, 1'b1, 1'b1, 16'h003B, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("[TB] branches");
    applyStimulus(32'h0000_0100, 32'hB000_0100, 0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h0000_0100, 32'hB000_0101, 0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("[TB] jumps");
    applyStimulus(32'h0000_0110, 32'hC000_0110, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0000);
    applyStimulus(32'h0040_0000, 32'hC040_0000, 0, 1'b1, 1'b0, 16'h0, 1'b1, 26'h000_0010, 1'b0, 32'h0);
    applyStimulus(32'h0000_0040, 32'hC000_0040, 0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h3FF_FFFF, 1'b1, 32'hFFFF_FFFC);

    $display("[TB] wrap at top of address space");
    applyStimulus(32'hFFFF_FFFC, 32'hD000_FFFC, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("[TB] reset during S_WAIT, stale rvalid afterwards");
    req_q.push_back(32'h0000_0000);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_imem_valid", {31'b0, imem_valid}, 32'd1);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    checkOutput("stale_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("stale_instr", instr, 32'h0);
    checkOutput("stale_pc", pc, 32'h0);

    $display("[TB] JR to misaligned target 0x1002");
    applyStimulus(32'h0000_0000, 32'hE000_0000, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_1002);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      checkOutput("trap_misalign", {31'b0, misalign}, 32'd1);
      checkOutput("trap_no_req", {31'b0, imem_valid}, 32'd0);
      checkOutput("trap_instr_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    checkOutput("trap_pc", pc, 32'h0);
`else
    applyStimulus(32'h0000_1000, 32'hE000_1000, 0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("no_misalign", {31'b0, misalign}, 32'd0);
`endif

    tick();
    checkOutput("req_q_empty", 32'(req_q.size()), 32'd0);
    checkOutput("instr_q_empty", 32'(instr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
